// File: rtl/sh7604_ext_slave_pkg.sv
// Shared types and constants for the SH7604 external-bus responder.
package sh7604_ext_slave_pkg;

    // Responder cycle state: idle, waiting on backend, waiting on vector, holding read data
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        VREQ  = 2'd2,
        DRIVE = 2'd3
    } slave_state_t;

    // Default number of CE_R periods an access may wait before it is aborted
    localparam int DEFAULT_TIMEOUT = 255;

    // Reads always fetch the full 32-bit word from the backend
    localparam logic [3:0] READ_BE = 4'hF;

endpackage

// File: rtl/sh7604_ext_slave.sv
// SH7604 external-bus responder: decodes one chip-select area plus interrupt
// vector fetches, holds the master on WAIT_N while an arbitrary-latency
// backend completes, then presents read data on DO.
module sh7604_ext_slave
    import sh7604_ext_slave_pkg::*;
#(
    parameter int AW      = 25,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter bit VEC_EN  = 1'b1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CE_R,
    input  logic          CE_F,
    input  logic [26:0]   A,
    input  logic          BS_N,
    input  logic          CS_N,
    input  logic          RD_WR_N,
    input  logic          RD_N,
    input  logic [3:0]    WE_N,
    input  logic          IVECF_N,
    input  logic [31:0]   DI,
    output logic [31:0]   DO,
    output logic          DOE,
    output logic          WAIT_N,
    output logic [AW-1:0] MEM_A,
    output logic [31:0]   MEM_WD,
    output logic [3:0]    MEM_BE,
    output logic          MEM_WE,
    output logic          MEM_REQ,
    input  logic          MEM_ACK,
    input  logic [31:0]   MEM_RD,
    output logic          VEC_REQ,
    output logic [3:0]    VEC_LVL,
    input  logic          VEC_ACK,
    input  logic [7:0]    VEC_DI,
    output logic          ERR
);

    // Timeout fires on the CE_R that would bring the count up to TIMEOUT
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    slave_state_t state;
    slave_state_t state_nx;
    logic [7:0]   tmo_cnt;

    logic mem_start;
    logic vec_start;
    logic waiting;
    logic start_take;
    logic mem_ack_ok;
    logic vec_ack_ok;
    logic any_ack;
    logic abort_ev;
    logic tmo_ev;
    logic release_ev;

    // RD_N is informational and CE_F needs no logic because DO only moves on completions
    logic unused_pins;
    assign unused_pins = ^{RD_N, CE_F, A[26:AW]};

    // Pin-level start decode; a memory start wins over a simultaneous vector start
    always_comb begin
        mem_start = ~BS_N & ~CS_N;
        vec_start = ~BS_N & ~IVECF_N & VEC_EN & ~mem_start;
    end

    // Cycle events and the combinational wait request to the master
    always_comb begin
        waiting    = (state == MREQ) || (state == VREQ);
        start_take = CE_R && ((state == IDLE) || (state == DRIVE)) && (mem_start || vec_start);
        mem_ack_ok = (state == MREQ) && MEM_REQ && MEM_ACK;
        vec_ack_ok = (state == VREQ) && VEC_REQ && VEC_ACK;
        any_ack    = mem_ack_ok || vec_ack_ok;
        abort_ev   = waiting && CE_R && CS_N && IVECF_N && !any_ack;
        tmo_ev     = waiting && CE_R && (tmo_cnt == TMO_LAST) && !any_ack && !abort_ev;
        release_ev = (state == DRIVE) && CE_R && !start_take && CS_N && IVECF_N;
        WAIT_N     = !RST_N || !(mem_start || vec_start || waiting);
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DRIVE: begin
                if (start_take) begin
                    state_nx = mem_start ? MREQ : VREQ;
                end else if (release_ev) begin
                    state_nx = IDLE;
                end
            end
            MREQ, VREQ: begin
                if (any_ack || tmo_ev) begin
                    state_nx = DRIVE;
                end else if (abort_ev) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Timeout counter: cleared per cycle start, advanced on each CE_R while waiting
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if (start_take) begin
            tmo_cnt <= '0;
        end else if (waiting && CE_R) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Registered bus and backend outputs, updated by the cycle events above
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DO      <= '0;
            DOE     <= 1'b0;
            MEM_A   <= '0;
            MEM_WD  <= '0;
            MEM_BE  <= '0;
            MEM_WE  <= 1'b0;
            MEM_REQ <= 1'b0;
            VEC_REQ <= 1'b0;
            VEC_LVL <= '0;
            ERR     <= 1'b0;
        end else begin
            ERR <= 1'b0;
            if (start_take) begin
                DOE <= 1'b0;
                if (mem_start) begin
                    MEM_A   <= A[AW-1:0];
                    MEM_WE  <= ~RD_WR_N;
                    MEM_WD  <= DI;
                    MEM_BE  <= RD_WR_N ? READ_BE : ~WE_N;
                    MEM_REQ <= 1'b1;
                end else begin
                    VEC_LVL <= A[3:0];
                    VEC_REQ <= 1'b1;
                end
            end else if (mem_ack_ok) begin
                MEM_REQ <= 1'b0;
                if (!MEM_WE) begin
                    DO  <= MEM_RD;
                    DOE <= 1'b1;
                end
            end else if (vec_ack_ok) begin
                DO      <= {24'h0, VEC_DI};
                DOE     <= 1'b1;
                VEC_REQ <= 1'b0;
            end else if (tmo_ev) begin
                MEM_REQ <= 1'b0;
                VEC_REQ <= 1'b0;
                DO      <= 32'hFFFF_FFFF;
                DOE     <= 1'b1;
                ERR     <= 1'b1;
            end else if (abort_ev) begin
                MEM_REQ <= 1'b0;
                VEC_REQ <= 1'b0;
            end else if (release_ev) begin
                DOE <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sh7604_ext_slave.md
Name: sh7604_ext_slave

Overview:
- Target/responder side of the SH7604 external bus, driven by the SH7604 bus-state controller master.
- Decodes one chip-select area plus interrupt-vector-fetch cycles. Holds the master with WAIT_N while a backend memory/peripheral port completes the request, then returns read data on the master's data-in bus.
- Lets FPGA-side memories of arbitrary latency (SDRAM controller, BRAM, register files, interrupt controller) sit behind a normal SRAM-type area.

Parameters:
- AW, 25: backend address width; forwarded address is A[AW-1:0].
- TIMEOUT, 255: CE_R cycles an access may wait for backend ack before it is aborted (1..255).
- VEC_EN, 1: 1 = respond to vector-fetch cycles (IVECF_N low); 0 = ignore them.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- CE_R  in  1  bus rising-phase clock enable; same enable the master uses.
- CE_F  in  1  bus falling-phase clock enable.
- A  in  27  master address.
- BS_N  in  1  bus-cycle start strobe.
- CS_N  in  1  this area's chip select.
- RD_WR_N  in  1  1 = read, 0 = write.
- RD_N  in  1  read strobe.
- WE_N  in  4  byte write strobes; [3] = D31..24.
- IVECF_N  in  1  vector-fetch cycle flag.
- DI  in  32  write data from master.
- DO  out  32  read data to master.
- DOE  out  1  DO valid/drive enable.
- WAIT_N  out  1  wait request to master; 0 = hold.
- MEM_A  out  AW  backend address.
- MEM_WD  out  32  backend write data.
- MEM_BE  out  4  backend byte enables.
- MEM_WE  out  1  backend write.
- MEM_REQ  out  1  backend request, level.
- MEM_ACK  in  1  backend completion, 1-clock pulse.
- MEM_RD  in  32  backend read data, valid with MEM_ACK.
- VEC_REQ  out  1  vector request to interrupt controller.
- VEC_LVL  out  4  level, from A[3:0].
- VEC_ACK  in  1  vector ready, pulse.
- VEC_DI  in  8  vector number.
- ERR  out  1  1-clock pulse on timeout abort.

Behaviour:
- Reset values: DO=0, DOE=0, MEM_*=0, VEC_REQ=0, VEC_LVL=0, ERR=0, state IDLE, WAIT_N=1.
- States (in SH7604_PKG): IDLE, MREQ, VREQ, DRIVE.
- Cycle start, sampled on CE_R in IDLE or DRIVE:
  - Memory start = BS_N=0 and CS_N=0.
  - Vector start = BS_N=0, IVECF_N=0, VEC_EN=1.
  - Memory start wins if both are present.
- WAIT_N is combinational, low when any of these holds:
  - a start is present on the pins (no CE qualification);
  - state is MREQ or VREQ.
  - This keeps zero-wait-area and vector cycles held on their first sampling CE_R.
- Memory start:
  - Latch MEM_A=A[AW-1:0], MEM_WE=~RD_WR_N, MEM_WD=DI.
  - MEM_BE = ~WE_N on write, 4'hF on read.
  - Set MEM_REQ=1, clear DOE, clear timeout counter; go to MREQ.
- MREQ: ack is valid only while MEM_REQ=1 on the same clock. On MEM_ACK:
  - MEM_REQ=0.
  - Read: DO=MEM_RD, DOE=1.
  - Write: DO unchanged.
  - Go to DRIVE, so WAIT_N rises the next clock.
- Earliest ack is 1 clock after MEM_REQ rises. The master samples WAIT_N high on the following CE_R and DO on the CE_F after that.
- Vector start:
  - VEC_LVL=A[3:0], VEC_REQ=1; go to VREQ.
  - On VEC_ACK: DO={24'h0,VEC_DI}, DOE=1, VEC_REQ=0; go to DRIVE.
- DRIVE: DO/DOE held stable. On CE_R:
  - New start present (back-to-back with CS held low): begin a new cycle immediately.
  - Else CS_N=1 and IVECF_N=1: DOE=0; go to IDLE.
- Timeout:
  - Counter increments on CE_R in MREQ/VREQ.
  - When it reaches TIMEOUT: drop MEM_REQ/VEC_REQ, DO=32'hFFFFFFFF, DOE=1, pulse ERR, go to DRIVE.
  - An ack in the same clock as the timeout takes priority (normal completion, no ERR).
- Abort: CS_N and IVECF_N both high on CE_R while in MREQ/VREQ (master reset mid-cycle):
  - Drop MEM_REQ/VEC_REQ; go to IDLE; no ERR.
  - A late ack is ignored.
- In IDLE, BS_N low with CS_N high and IVECF_N high is ignored; WAIT_N stays 1.
- RD_N is informational only; direction comes from RD_WR_N.
- CE_F is unused except that DO must not change between the release-WAIT_N CE_R and the next CE_R.

Decomposition:
- SH7604_PKG: slave state enum, default TIMEOUT constant, 4'hF read byte-enable constant.
- Single module; no natural sub-module. The timeout counter stays inline.

Test Plan:
- Read, 3-clock backend latency: A=0x0000100, ack with MEM_RD=0x12345678 → MEM_A=0x100, MEM_BE=F; WAIT_N low until ack+1; DO=0x12345678 at master CE_F.
- Byte write: WE_N=4'b1011, DI=0xAABBCCDD → MEM_WE=1, MEM_BE=4'b0100, MEM_WD=0xAABBCCDD; WAIT_N held until ack.
- Back-to-back 16-bit pair: second BS_N while in DRIVE with CS_N low → second MEM_REQ issued with no IDLE visit; both data returned correctly.
- Vector fetch: IVECF_N=0, A[3:0]=0xB, VEC_DI=0x47 → VEC_LVL=0xB, WAIT_N low on the first TV1 sample; DO=0x00000047.
- Timeout: TIMEOUT=4, no ack → ERR pulse after 4 CE_R; DO=0xFFFFFFFF; MEM_REQ=0; a late MEM_ACK is ignored.
- Abort/reset: CS_N high mid-MREQ → IDLE, WAIT_N=1, no ERR. RST_N low mid-VREQ → all outputs at reset values at once.
